// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: latches one pipeline load/store, presents it level-stably to
// the cache controller until it completes, errors or times out, then returns
// a one-cycle response. Also keeps saturating hit/miss statistics.
module mem_req_ctrl #(
    parameter int TIMEOUT = 64,   // 2..255 WAIT cycles before abort
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_en,
    input  logic             mem_wr,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_wdata,
    input  logic             cnt_clr,
    output logic             stall,
    output logic [15:0]      rdata,
    output logic             rvalid,
    output logic             mem_err,
    output logic [15:0]      addr,
    output logic [15:0]      data_in,
    output logic             read,
    output logic             write,
    input  logic [15:0]      fs_data_out,
    input  logic             fs_done,
    input  logic             fs_cachehit,
    input  logic             fs_err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Last WAIT cycle index before the request is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic               err_q, err_d;
    logic [15:0]        rdata_q, rdata_d;
    logic [7:0]         tmo_q, tmo_d;
    logic [CNT_W-1:0]   hit_q, hit_d;
    logic [CNT_W-1:0]   miss_q, miss_d;
    logic               hit_inc, miss_inc;

    // The controller sees only registered request fields, so addr/data_in
    // never glitch and hold their last value outside WAIT.
    assign addr     = addr_q;
    assign data_in  = wdata_q;
    assign rdata    = rdata_q;
    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;

    // State and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            tmo_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    // Next-state and output decode for the request FSM.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        tmo_d    = tmo_q;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        stall    = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        rvalid   = 1'b0;
        mem_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = mem_en;
                if (mem_en) begin
                    if (mem_addr[0]) begin
                        // Misaligned: never bother the controller.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else begin
                        addr_d  = mem_addr;
                        wdata_d = mem_wdata;
                        wr_d    = mem_wr;
                        tmo_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                read  = ~wr_q;
                write = wr_q;
                tmo_d = tmo_q + 8'd1;
                if (fs_err) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (fs_done) begin
                    rdata_d  = wr_q ? 16'h0000 : fs_data_out;
                    hit_inc  = fs_cachehit;
                    miss_inc = ~fs_cachehit;
                    state_d  = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // mem_en here belongs to the completing instruction.
                rvalid  = 1'b1;
                mem_err = err_q;
                err_d   = 1'b0;
                tmo_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (cnt_clr) begin
            hit_d  = '0;
            miss_d = '0;
        end else begin
            if (hit_inc && (hit_q != {CNT_W{1'b1}}))
                hit_d = hit_q + CNT_W'(1);
            if (miss_inc && (miss_q != {CNT_W{1'b1}}))
                miss_d = miss_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed cases then random requests,
// each predicted from the request/response rules by a transaction-level model.
module tb_mem_req_ctrl;

    localparam int TO   = 64;
    localparam int CW   = 4;          // narrow counters so saturation is reachable
    localparam int CMAX = (1 << CW) - 1;
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_en = 1'b0, mem_wr = 1'b0, cnt_clr = 1'b0;
    logic [15:0]   mem_addr = '0, mem_wdata = '0;
    logic          stall, rvalid, mem_err, read, write;
    logic [15:0]   rdata, addr, data_in;
    logic [15:0]   fs_data_out = '0;
    logic          fs_done = 1'b0, fs_cachehit = 1'b0, fs_err = 1'b0;
    logic [CW-1:0] hit_cnt, miss_cnt;

    int vectors = 0;
    int miscompares = 0;
    int exp_hit = 0;
    int exp_miss = 0;

    mem_req_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cnt_clr(cnt_clr),
        .stall(stall), .rdata(rdata), .rvalid(rvalid), .mem_err(mem_err),
        .addr(addr), .data_in(data_in), .read(read), .write(write),
        .fs_data_out(fs_data_out), .fs_done(fs_done),
        .fs_cachehit(fs_cachehit), .fs_err(fs_err),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request. d/e: WAIT-cycle index at which fs_done/fs_err fire
    // (NEVER = not at all). clr_at: bench cycle index of a cnt_clr pulse (-1 none).
    task automatic run_txn(input string tag, input bit wr, input logic [15:0] a,
                           input logic [15:0] wd, input int d, input int e,
                           input bit hit, input logic [15:0] rdv, input int clr_at);
        bit   mis, succ, seen;
        int   waits, exp_resp, inc_cycle, clr, stall_n, rd_n, wr_n, resp_k, ea;
        logic [15:0] exp_rdata, got_rdata;
        logic got_err, addr_ok;

        // Transaction-level prediction.
        mis  = a[0];
        succ = !mis && (d < e) && (d <= TO - 1);
        if (mis)       waits = 0;
        else if (succ) waits = d + 1;
        else           waits = ((e < TO - 1) ? e : TO - 1) + 1;
        exp_resp  = 1 + waits;
        exp_rdata = (succ && !wr) ? rdv : 16'h0000;
        clr       = (clr_at > exp_resp) ? exp_resp : clr_at;
        inc_cycle = succ ? d + 1 : -1;
        if (clr >= 0 && clr < inc_cycle) begin exp_hit = 0; exp_miss = 0; end
        if (succ) begin
            if (hit) exp_hit  = (exp_hit  < CMAX) ? exp_hit + 1  : CMAX;
            else     exp_miss = (exp_miss < CMAX) ? exp_miss + 1 : CMAX;
        end
        if (clr >= 0 && clr >= inc_cycle) begin exp_hit = 0; exp_miss = 0; end

        stall_n = 0; rd_n = 0; wr_n = 0; resp_k = -1; seen = 0;
        got_rdata = '0; got_err = 1'b0; addr_ok = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            ea = k - 1;
            // Issue at k==0; re-present a request during the expected RESP cycle,
            // which must be ignored. Other cycles carry junk on the request bus.
            mem_en    = (k == 0) || (k == exp_resp);
            mem_wr    = (k == 0) ? wr : 1'($urandom);
            mem_addr  = (k == 0) ? a : 16'($urandom);
            mem_wdata = (k == 0) ? wd : 16'($urandom);
            cnt_clr   = (k == clr);
            fs_cachehit = (k == 0) ? 1'($urandom) : hit;
            fs_done   = (k >= 1) ? (ea == d) : 1'($urandom);
            fs_err    = (k >= 1) ? (ea == e) : 1'($urandom);
            fs_data_out = (k >= 1 && ea == d) ? rdv : 16'($urandom);
            #1;
            stall_n += int'(stall);
            rd_n    += int'(read);
            wr_n    += int'(write);
            if ((read || write) && (addr !== a || data_in !== wd)) addr_ok = 1'b0;
            if (rvalid) begin
                seen = 1; resp_k = k; got_rdata = rdata; got_err = mem_err;
                break;
            end
        end
        chk({tag, ":rvalid_seen"}, 32'(seen), 32'd1);
        chk({tag, ":resp_cycle"}, 32'(resp_k), 32'(exp_resp));
        chk({tag, ":stall_cycles"}, 32'(stall_n), 32'(1 + waits));
        chk({tag, ":read_cycles"}, 32'(rd_n), wr ? 32'd0 : 32'(waits));
        chk({tag, ":write_cycles"}, 32'(wr_n), wr ? 32'(waits) : 32'd0);
        chk({tag, ":addr_data_in"}, 32'(addr_ok), 32'd1);
        chk({tag, ":mem_err"}, 32'(got_err), 32'(!succ));
        chk({tag, ":rdata"}, 32'(got_rdata), 32'(exp_rdata));
        // One quiet cycle after RESP: pulse gone, counters settled.
        @(negedge clk);
        mem_en = 1'b0; cnt_clr = 1'b0; fs_done = 1'b0; fs_err = 1'b0;
        #1;
        chk({tag, ":rvalid_pulse"}, 32'(rvalid), 32'd0);
        chk({tag, ":hit_cnt"}, 32'(hit_cnt), 32'(exp_hit));
        chk({tag, ":miss_cnt"}, 32'(miss_cnt), 32'(exp_miss));
        $display("txn %s wr=%0d addr=%h waits=%0d err=%0d rdata=%h hit=%0d miss=%0d",
                 tag, wr, a, waits, got_err, got_rdata, hit_cnt, miss_cnt);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        #12;
        chk("reset_outs", {26'd0, stall, rvalid, mem_err, read, write, 1'b0},
            32'd0);
        chk("reset_bus", {addr, data_in}, 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_cnts", {24'd0, hit_cnt, miss_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_txn("load_hit",   1'b0, 16'h0010, 16'h0000, 2, NEVER, 1'b1, 16'hBEEF, -1);
        run_txn("store_miss", 1'b1, 16'h0024, 16'h1234, 0, NEVER, 1'b0, 16'h5555, -1);
        run_txn("misaligned", 1'b0, 16'h0011, 16'h0000, 0, NEVER, 1'b1, 16'h7777, -1);
        run_txn("timeout",    1'b0, 16'h0030, 16'h0000, NEVER, NEVER, 1'b1, 16'h0000, -1);
        run_txn("err_and_done", 1'b0, 16'h0032, 16'h0000, 1, 1, 1'b1, 16'hAAAA, -1);

        // Reset while WAITing abandons the request.
        @(negedge clk);
        mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 16'h0040; mem_wdata = 16'h9999;
        @(negedge clk);
        mem_en = 1'b0;
        #1;
        chk("rst_pre_read", 32'(read), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outs", {26'd0, stall, rvalid, mem_err, read, write, 1'b0}, 32'd0);
        chk("rst_async_bus", {addr, data_in}, 32'd0);
        chk("rst_async_cnts", {24'd0, hit_cnt, miss_cnt}, 32'd0);
        exp_hit = 0; exp_miss = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("rst_no_rvalid", {30'd0, rvalid, read}, 32'd0);
        end
        run_txn("post_rst_load", 1'b0, 16'h0042, 16'h0000, 1, NEVER, 1'b0, 16'hC0DE, -1);

        // Clear coinciding with done: clear wins.
        run_txn("clr_with_done", 1'b0, 16'h0050, 16'h0000, 1, NEVER, 1'b1, 16'h1111, 2);

        // Saturation of the hit counter.
        for (int i = 0; i < CMAX + 2; i++)
            run_txn("sat_hit", 1'b0, 16'h0060, 16'h0000, 0, NEVER, 1'b1, 16'(i), -1);

        // Random requests.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            int rd, re, rc;
            ra    = 16'($urandom);
            ra[0] = ($urandom_range(0, 7) == 0);
            rd    = ($urandom_range(0, 15) == 0) ? NEVER : int'($urandom_range(0, 6));
            re    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : NEVER;
            rc    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_txn("random", 1'($urandom), ra, 16'($urandom), rd, re,
                    1'($urandom), 16'($urandom), rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
